// File: rtl/score_keeper_if.sv
// rtl/score_keeper_if.sv - game-phase controls in, score digits and state flags out
interface score_keeper_if;
  logic       Start;
  logic       Ack;
  logic       Score;
  logic       Lose;
  logic       Tick_EN;
  logic [3:0] SSD3;
  logic [3:0] SSD2;
  logic [3:0] SSD1;
  logic [3:0] SSD0;
  logic [3:0] Blank;
  logic       Q_Idle;
  logic       Q_Play;
  logic       Q_Over;
  logic       New_High;

  modport master (
    output Start, Ack, Score, Lose, Tick_EN,
    input  SSD3, SSD2, SSD1, SSD0, Blank, Q_Idle, Q_Play, Q_Over, New_High
  );

  modport slave (
    input  Start, Ack, Score, Lose, Tick_EN,
    output SSD3, SSD2, SSD1, SSD0, Blank, Q_Idle, Q_Play, Q_Over, New_High
  );
endinterface

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - BCD score / high score keeper with idle/play/over game FSM
module score_keeper #(
  parameter int MAX_SCORE   = 99,
  parameter int BLINK_TICKS = 4
) (
  input  logic          Clk,
  input  logic          reset_n,
  score_keeper_if.slave sk
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  localparam logic [3:0] MAX_TENS   = 4'(MAX_SCORE / 10);
  localparam logic [3:0] MAX_ONES   = 4'(MAX_SCORE % 10);
  localparam logic [3:0] BLINK_LAST = 4'(BLINK_TICKS - 1);
  localparam logic [3:0] BLANK_HI   = 4'b1100;

  state_t     state_q, state_d;
  logic [3:0] cur_tens_q, cur_tens_d;
  logic [3:0] cur_ones_q, cur_ones_d;
  logic [3:0] hi_tens_q, hi_tens_d;
  logic [3:0] hi_ones_q, hi_ones_d;
  logic       new_high_q, new_high_d;
  logic [3:0] blink_cnt_q, blink_cnt_d;
  logic       blink_phase_q, blink_phase_d;
  logic [3:0] blank_q, blank_d;

  logic [3:0] inc_tens, inc_ones;
  logic [3:0] fin_tens, fin_ones;
  logic       at_max;
  logic       beats_high;

  // BCD increment that saturates at MAX_SCORE; the score only ever steps by one,
  // so it can never skip past the saturation point.
  always_comb begin
    at_max   = (cur_tens_q == MAX_TENS) && (cur_ones_q == MAX_ONES);
    inc_tens = cur_tens_q;
    inc_ones = cur_ones_q;
    if (!at_max) begin
      if (cur_ones_q == 4'd9) begin
        inc_ones = 4'd0;
        inc_tens = cur_tens_q + 4'd1;
      end else begin
        inc_ones = cur_ones_q + 4'd1;
      end
    end
  end

  // A Score pulse in the losing cycle counts before the high-score compare.
  always_comb begin
    fin_tens   = sk.Score ? inc_tens : cur_tens_q;
    fin_ones   = sk.Score ? inc_ones : cur_ones_q;
    beats_high = (fin_tens > hi_tens_q) ||
                 ((fin_tens == hi_tens_q) && (fin_ones > hi_ones_q));
  end

  always_comb begin
    state_d       = state_q;
    cur_tens_d    = cur_tens_q;
    cur_ones_d    = cur_ones_q;
    hi_tens_d     = hi_tens_q;
    hi_ones_d     = hi_ones_q;
    new_high_d    = new_high_q;
    blink_cnt_d   = 4'd0;
    blink_phase_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sk.Start) begin
          state_d    = S_PLAY;
          cur_tens_d = 4'd0;
          cur_ones_d = 4'd0;
          new_high_d = 1'b0;
        end
      end
      S_PLAY: begin
        cur_tens_d = fin_tens;
        cur_ones_d = fin_ones;
        if (sk.Lose) begin
          state_d    = S_OVER;
          new_high_d = beats_high;
          if (beats_high) begin
            hi_tens_d = fin_tens;
            hi_ones_d = fin_ones;
          end
        end
      end
      S_OVER: begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (sk.Ack) begin
          state_d       = S_IDLE;
          blink_cnt_d   = 4'd0;
          blink_phase_d = 1'b0;
        end else if (sk.Tick_EN) begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = 4'd0;
            blink_phase_d = ~blink_phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_PLAY:  blank_d = 4'b0000;
      S_OVER:  blank_d = blink_phase_d ? BLANK_HI : 4'b0000;
      default: blank_d = BLANK_HI;
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cur_tens_q    <= 4'd0;
      cur_ones_q    <= 4'd0;
      hi_tens_q     <= 4'd0;
      hi_ones_q     <= 4'd0;
      new_high_q    <= 1'b0;
      blink_cnt_q   <= 4'd0;
      blink_phase_q <= 1'b0;
      blank_q       <= BLANK_HI;
    end else begin
      state_q       <= state_d;
      cur_tens_q    <= cur_tens_d;
      cur_ones_q    <= cur_ones_d;
      hi_tens_q     <= hi_tens_d;
      hi_ones_q     <= hi_ones_d;
      new_high_q    <= new_high_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      blank_q       <= blank_d;
    end
  end

  assign sk.SSD3     = cur_tens_q;
  assign sk.SSD2     = cur_ones_q;
  assign sk.SSD1     = hi_tens_q;
  assign sk.SSD0     = hi_ones_q;
  assign sk.Blank    = blank_q;
  assign sk.New_High = new_high_q;
  assign sk.Q_Idle   = (state_q == S_IDLE);
  assign sk.Q_Play   = (state_q == S_PLAY);
  assign sk.Q_Over   = (state_q == S_OVER);

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - randomized and directed checks of score_keeper against a decimal model
module tb_score_keeper;
  localparam int MAX_SCORE   = 99;
  localparam int BLINK_TICKS = 4;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  // reference model: plain integers, 0 idle / 1 play / 2 over
  int m_state;
  int m_score;
  int m_high;
  int m_nh;
  int m_ticks;

  score_keeper_if sk_if ();

  score_keeper #(
    .MAX_SCORE  (MAX_SCORE),
    .BLINK_TICKS(BLINK_TICKS)
  ) dut (
    .Clk    (clk),
    .reset_n(reset_n),
    .sk     (sk_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_score = 0;
    m_high  = 0;
    m_nh    = 0;
    m_ticks = 0;
  endtask

  task automatic model_step(input logic st, input logic ak, input logic sc,
                            input logic lo, input logic tk);
    case (m_state)
      0: if (st) begin
        m_state = 1;
        m_score = 0;
        m_nh    = 0;
      end
      1: begin
        if (sc && m_score < MAX_SCORE) m_score++;
        if (lo) begin
          if (m_score > m_high) begin
            m_high = m_score;
            m_nh   = 1;
          end else begin
            m_nh = 0;
          end
          m_state = 2;
          m_ticks = 0;
        end
      end
      default: begin
        if (ak) begin
          m_state = 0;
          m_ticks = 0;
        end else if (tk) begin
          m_ticks++;
        end
      end
    endcase
  endtask

  function automatic logic [3:0] exp_blank();
    if (m_state == 0) return 4'b1100;
    if (m_state == 1) return 4'b0000;
    return (((m_ticks / BLINK_TICKS) % 2) == 1) ? 4'b1100 : 4'b0000;
  endfunction

  task automatic check_all(input string pfx);
    check({pfx, "_ssd3"},  32'(sk_if.SSD3),     32'(m_score / 10));
    check({pfx, "_ssd2"},  32'(sk_if.SSD2),     32'(m_score % 10));
    check({pfx, "_ssd1"},  32'(sk_if.SSD1),     32'(m_high / 10));
    check({pfx, "_ssd0"},  32'(sk_if.SSD0),     32'(m_high % 10));
    check({pfx, "_blank"}, 32'(sk_if.Blank),    32'(exp_blank()));
    check({pfx, "_nh"},    32'(sk_if.New_High), 32'(m_nh));
    check({pfx, "_qidle"}, 32'(sk_if.Q_Idle),   32'(m_state == 0));
    check({pfx, "_qplay"}, 32'(sk_if.Q_Play),   32'(m_state == 1));
    check({pfx, "_qover"}, 32'(sk_if.Q_Over),   32'(m_state == 2));
  endtask

  task automatic cycle(input logic st, input logic ak, input logic sc,
                       input logic lo, input logic tk);
    sk_if.Start   = st;
    sk_if.Ack     = ak;
    sk_if.Score   = sc;
    sk_if.Lose    = lo;
    sk_if.Tick_EN = tk;
    @(posedge clk);
    model_step(st, ak, sc, lo, tk);
    #1;
    sk_if.Start   = 1'b0;
    sk_if.Ack     = 1'b0;
    sk_if.Score   = 1'b0;
    sk_if.Lose    = 1'b0;
    sk_if.Tick_EN = 1'b0;
    check_all("cyc");
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset_n       = 1'b0;
    sk_if.Start   = 1'b0;
    sk_if.Ack     = 1'b0;
    sk_if.Score   = 1'b0;
    sk_if.Lose    = 1'b0;
    sk_if.Tick_EN = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check("reset_blank", 32'(sk_if.Blank), 32'hC);
    reset_n = 1'b1;

    // first game: 3 points
    cycle(1, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 1, 0, 0);
    check("tp1_ssd3", 32'(sk_if.SSD3), 0);
    check("tp1_ssd2", 32'(sk_if.SSD2), 3);
    check("tp1_qplay", 32'(sk_if.Q_Play), 1);
    check("tp1_blank", 32'(sk_if.Blank), 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 0);

    // 12 points sets a new high
    cycle(1, 0, 0, 0, 0);
    repeat (12) cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0);
    check("tp2_qover", 32'(sk_if.Q_Over), 1);
    check("tp2_ssd1", 32'(sk_if.SSD1), 1);
    check("tp2_ssd0", 32'(sk_if.SSD0), 2);
    check("tp2_nh", 32'(sk_if.New_High), 1);

    // game-over blink
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 0, 0, 1);
      if (i == 3) check("blink_t3", 32'(sk_if.Blank), 32'h0);
      if (i == 4) check("blink_t4", 32'(sk_if.Blank), 32'hC);
      if (i == 7) check("blink_t7", 32'(sk_if.Blank), 32'hC);
      if (i == 8) check("blink_t8", 32'(sk_if.Blank), 32'h0);
    end
    cycle(0, 1, 0, 0, 0);
    check("ack_qidle", 32'(sk_if.Q_Idle), 1);
    check("ack_blank", 32'(sk_if.Blank), 32'hC);
    check("ack_nh_kept", 32'(sk_if.New_High), 1);
    cycle(0, 0, 1, 1, 1);
    check("idle_lose_ign", 32'(sk_if.Q_Idle), 1);

    // 9 points then score+lose together -> 10, not a new high
    cycle(1, 0, 0, 0, 0);
    repeat (9) cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 1, 0);
    check("tp3_ssd3", 32'(sk_if.SSD3), 1);
    check("tp3_ssd2", 32'(sk_if.SSD2), 0);
    check("tp3_hi", 32'({sk_if.SSD1, sk_if.SSD0}), 32'h12);
    check("tp3_nh", 32'(sk_if.New_High), 0);
    cycle(1, 1, 0, 0, 0);
    check("ack_start_qidle", 32'(sk_if.Q_Idle), 1);

    // asynchronous reset mid-play
    cycle(1, 0, 0, 0, 0);
    repeat (2) cycle(0, 0, 1, 0, 0);
    check("pre_rst_hi", 32'({sk_if.SSD1, sk_if.SSD0}), 32'h12);
    reset_n = 1'b0;
    #2;
    model_reset();
    check_all("async_rst");
    check("async_rst_hi", 32'({sk_if.SSD1, sk_if.SSD0}), 0);
    check("async_rst_qidle", 32'(sk_if.Q_Idle), 1);
    #2;
    reset_n = 1'b1;

    // saturation at MAX_SCORE
    cycle(1, 0, 0, 0, 0);
    for (int i = 1; i <= 120; i++) begin
      cycle(0, 0, 1, 0, 0);
      if (i == 9)   check("sat_9",   32'({sk_if.SSD3, sk_if.SSD2}), 32'h09);
      if (i == 10)  check("sat_10",  32'({sk_if.SSD3, sk_if.SSD2}), 32'h10);
      if (i == 19)  check("sat_19",  32'({sk_if.SSD3, sk_if.SSD2}), 32'h19);
      if (i == 20)  check("sat_20",  32'({sk_if.SSD3, sk_if.SSD2}), 32'h20);
      if (i == 120) check("sat_120", 32'({sk_if.SSD3, sk_if.SSD2}), 32'h99);
    end
    cycle(0, 0, 0, 1, 0);
    check("sat_hi", 32'({sk_if.SSD1, sk_if.SSD0}), 32'h99);
    cycle(0, 1, 0, 0, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic st, ak, sc, lo, tk;
      st = ($urandom_range(0, 99) < 8);
      ak = ($urandom_range(0, 99) < 5);
      sc = ($urandom_range(0, 99) < 45);
      lo = ($urandom_range(0, 99) < 3);
      tk = ($urandom_range(0, 99) < 35);
      if (n % 1000 == 999) begin
        reset_n = 1'b0;
        #2;
        model_reset();
        check_all("rnd_rst");
        #2;
        reset_n = 1'b1;
      end
      cycle(st, ak, sc, lo, tk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
